// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, bit-timing
// arithmetic, 3-sample majority vote and stop-time flag priority.
// The optional parity feature is selected with the UART_RX_PARITY_EN macro
// (see uart_rx_sampler.sv); the encodings here cover both builds.
package uart_pkg;

  localparam int DEF_INPUT_CLOCK = 16_000_000;
  localparam int DEF_BAUD        = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Outcome of the stop-bit sample. A framing error outranks a parity
  // error so that exactly one flag pulses per bad frame.
  typedef enum logic [1:0] {
    RES_OK         = 2'd0,
    RES_FRAME_ERR  = 2'd1,
    RES_PARITY_ERR = 2'd2
  } frame_res_e;

  function automatic int calc_clks_per_bit(input int input_clock, input int baud);
    return input_clock / baud;
  endfunction

  function automatic int calc_mid(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic frame_res_e frame_result(input logic stop_bit, input logic parity_bad);
    if (!stop_bit)  return RES_FRAME_ERR;
    if (parity_bad) return RES_PARITY_ERR;
    return RES_OK;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Byte delivery interface between the RX sampler and the ring-buffer writer.
// Handshake: o_new_data rises with o_data valid and both hold until the
// consumer drives i_ack_data=1 for one cycle while o_new_data=1; o_new_data
// drops the following cycle. i_ack_data while o_new_data=0 has no effect.
// The error flags are single-cycle pulses and need no acknowledge.
interface uart_rx_sampler_if;
  logic [7:0] o_data;
  logic       o_new_data;
  logic       i_ack_data;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  modport master (
    output o_data, o_new_data, o_frame_err, o_overrun, o_parity_err,
    input  i_ack_data
  );

  modport slave (
    input  o_data, o_new_data, o_frame_err, o_overrun, o_parity_err,
    output i_ack_data
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, restarted by i_clear.
// o_sample marks the three mid-bit sample points, o_decide the last of them
// where the vote is taken. Kept generic so the TX side can reuse it.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 138
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_sample,
  output logic o_decide
);

  localparam int MID = calc_mid(CLKS_PER_BIT);
  localparam int CW  = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] S_LO  = CW'(MID - 1);
  localparam logic [CW-1:0] S_HI  = CW'(MID + 1);

  logic [CW-1:0] count;

  // Count one bit period and wrap; a clear restarts the period at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_sample = (count >= S_LO) && (count <= S_HI);
  assign o_decide = (count == S_HI);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start-edge detect, mid-bit majority sampling,
// 8N1 deframing (8E1 when UART_RX_PARITY_EN is defined) and byte delivery
// over the uart_rx_sampler_if new_data/ack_data handshake with framing,
// parity and overrun pulses. i_rx must already be synchronised to i_clk.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK = DEF_INPUT_CLOCK,
  parameter int BAUD        = DEF_BAUD
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  output state_e                    o_dbg_state,
  uart_rx_sampler_if.master         bus
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(INPUT_CLOCK, BAUD);

`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = ST_PARITY;
`else
  localparam state_e AFTER_DATA = ST_STOP;
`endif

  logic [1:0] rst_sync;
  logic       rst_n_int;
  state_e     state, state_n;
  logic       rx_prev;
  logic       rx_fall;
  logic [1:0] samp_q;
  logic       vote;
  logic       sample, decide, clear_timer;
  logic [7:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic       stop_ok, stop_frame_err, stop_parity_err;
  logic       parity_bad;
  frame_res_e res;

  // Reset asserts immediately but releases two clocks after i_rst_n rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (rst_n_int),
    .i_clear  (clear_timer),
    .o_sample (sample),
    .o_decide (decide)
  );

  // Previous line value for edge detect; starts low so a line held low out
  // of reset is not mistaken for a start bit.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) rx_prev <= 1'b0;
    else            rx_prev <= i_rx;
  end
  assign rx_fall = rx_prev & ~i_rx;

  // Keep the first two mid-bit samples; the third is the live line value.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int)             samp_q <= 2'b00;
    else if (sample && !decide) samp_q <= {samp_q[0], i_rx};
  end
  assign vote = maj3(samp_q[1], samp_q[0], i_rx);

`ifdef UART_RX_PARITY_EN
  logic parity_q, parity_n;

  // Received parity bit, captured in the PARITY state.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) parity_q <= 1'b0;
    else            parity_q <= parity_n;
  end
  assign parity_bad = ^{shift, parity_q};
`else
  assign parity_bad = 1'b0;
`endif

  assign res = frame_result(vote, parity_bad);

  // FSM state, shift register and bit index.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= ST_IDLE;
      shift <= 8'h00;
      idx   <= 3'd0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
    end
  end

  // Next-state and deframing decisions, all taken on the decision strobe.
  always_comb begin
    state_n         = state;
    shift_n         = shift;
    idx_n           = idx;
    clear_timer     = 1'b0;
    stop_ok         = 1'b0;
    stop_frame_err  = 1'b0;
    stop_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_n        = parity_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (rx_fall) begin
          clear_timer = 1'b1;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        if (decide) begin
          if (vote) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            idx_n   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_n[idx] = vote;
          if (idx == 3'd7) state_n = AFTER_DATA;
          else             idx_n   = idx + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide) begin
          parity_n = vote;
          state_n  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Return to IDLE at the sample point so a back-to-back start edge
        // in the second half of the stop bit is not missed.
        if (decide) begin
          state_n = ST_IDLE;
          unique case (res)
            RES_OK:         stop_ok         = 1'b1;
            RES_FRAME_ERR:  stop_frame_err  = 1'b1;
            RES_PARITY_ERR: stop_parity_err = 1'b1;
            default:        stop_ok         = 1'b0;
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output register: byte hand-off, acknowledge and single-cycle flags.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      bus.o_data       <= 8'h00;
      bus.o_new_data   <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_overrun    <= 1'b0;
      bus.o_parity_err <= 1'b0;
    end else begin
      bus.o_frame_err  <= stop_frame_err;
      bus.o_parity_err <= stop_parity_err;
      bus.o_overrun    <= 1'b0;
      if (stop_ok) begin
        if (bus.o_new_data && !bus.i_ack_data) begin
          bus.o_overrun <= 1'b1;
        end else begin
          bus.o_data     <= shift;
          bus.o_new_data <= 1'b1;
        end
      end else if (bus.i_ack_data) begin
        bus.o_new_data <= 1'b0;
      end
    end
  end

  assign o_dbg_state = state;

endmodule
